// File: rtl/rx_sync_filter.sv
// Multi-channel async input synchronizer with registered rise/fall pulses.
// Define SYNC_GLITCH_FILTER_EN to add a per-channel glitch filter after the chain.
module rx_sync_filter #(
  parameter int                WIDTH      = 1,
  parameter int                STAGES     = 3,
  parameter logic [WIDTH-1:0]  RESET_VAL  = {WIDTH{1'b1}},
  parameter int                FILTER_LEN = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic [WIDTH-1:0] glitch_det
);

  if (STAGES < 2 || STAGES > 8) begin : g_bad_stages
    $error("rx_sync_filter: STAGES must be in 2..8");
  end

  logic [WIDTH-1:0] stage [STAGES] = '{default: RESET_VAL};
  logic [WIDTH-1:0] s_last;
  logic [WIDTH-1:0] prev = RESET_VAL;
  logic [WIDTH-1:0] run_mask;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < STAGES; k++) stage[k] <= RESET_VAL;
    end else begin
      stage[0] <= async_in;
      for (int k = 1; k < STAGES; k++) stage[k] <= stage[k-1];
    end
  end

  assign s_last = stage[STAGES-1];

`ifdef SYNC_GLITCH_FILTER_EN
  if (FILTER_LEN < 1 || FILTER_LEN > 255) begin : g_bad_filter_len
    $error("rx_sync_filter: FILTER_LEN must be in 1..255");
  end

  localparam int            CW      = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_LEN - 1);

  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] glitch_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    logic [CW-1:0] cnt      = '0;
    logic          sync_r   = RESET_VAL[i];
    logic          glitch_r = 1'b0;

    // A disagreement must persist FILTER_LEN samples; a shorter one is a glitch.
    always_ff @(posedge clk) begin
      if (reset) begin
        cnt      <= '0;
        sync_r   <= RESET_VAL[i];
        glitch_r <= 1'b0;
      end else if (s_last[i] == sync_r) begin
        cnt      <= '0;
        glitch_r <= (cnt != '0);
      end else if (cnt == CNT_MAX) begin
        cnt      <= '0;
        sync_r   <= s_last[i];
        glitch_r <= 1'b0;
      end else begin
        cnt      <= cnt + 1'b1;
        glitch_r <= 1'b0;
      end
    end

    assign sync_q[i]   = sync_r;
    assign glitch_q[i] = glitch_r;
  end

  assign sync_out   = sync_q;
  assign glitch_det = glitch_q & run_mask;
`else
  assign sync_out   = s_last;
  assign glitch_det = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) prev <= RESET_VAL;
    else       prev <= sync_out;
  end

  // Pulses are forced low while reset is asserted, before the reset edge lands.
  assign run_mask   = {WIDTH{~reset}};
  assign rise_pulse = sync_out & ~prev & run_mask;
  assign fall_pulse = ~sync_out & prev & run_mask;

endmodule

// File: tb/tb_rx_sync_filter.sv
// Directed bench for rx_sync_filter: a STAGES=3 and a STAGES=2 instance, WIDTH=2.
// Expected latencies follow the build (SYNC_GLITCH_FILTER_EN adds FILTER_LEN=4).
module tb_rx_sync_filter;

`ifdef SYNC_GLITCH_FILTER_EN
  localparam int FLAT = 4;
`else
  localparam int FLAT = 0;
`endif
  localparam int L3 = 3 + FLAT;
  localparam int L2 = 2 + FLAT;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] a3 = 2'b00;
  logic [1:0] a2 = 2'b00;
  logic [1:0] so3, r3, f3, g3;
  logic [1:0] so2, r2, f2, g2;
  logic [1:0] o_sync, o_rise, o_fall, o_glitch;
  int         sel = 0;
  int         n_tests = 0;
  int         n_fail = 0;
  logic [1:0] exp_q[$];

  rx_sync_filter #(.WIDTH(2), .STAGES(3)) dut3 (
    .clk(clk), .reset(reset), .async_in(a3), .sync_out(so3),
    .rise_pulse(r3), .fall_pulse(f3), .glitch_det(g3)
  );

  rx_sync_filter #(.WIDTH(2), .STAGES(2)) dut2 (
    .clk(clk), .reset(reset), .async_in(a2), .sync_out(so2),
    .rise_pulse(r2), .fall_pulse(f2), .glitch_det(g2)
  );

  // clock/reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  always_comb begin
    o_sync   = so3;
    o_rise   = r3;
    o_fall   = f3;
    o_glitch = g3;
    if (sel != 0) begin
      o_sync   = so2;
      o_rise   = r2;
      o_fall   = f2;
      o_glitch = g2;
    end
  end

  task automatic check(input string tag, input logic [1:0] got, input logic [1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%b expected=%b at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int s, input logic [1:0] v);
    if (s != 0) a2 = v;
    else        a3 = v;
  endtask

  task automatic settle(input int s, input logic [1:0] v);
    sel = s;
    drive(s, v);
    repeat (((s != 0) ? L2 : L3) + 2) tick();
    check("settle_sync", o_sync, v);
  endtask

  // Hold a new level and expect it exactly 'lat' edges later with one edge pulse.
  task automatic transition(input string tag, input int s, input logic [1:0] nv);
    logic [1:0] ov, er, ef;
    int lat;
    sel = s;
    lat = (s != 0) ? L2 : L3;
    ov  = (s != 0) ? a2 : a3;
    er  = nv & ~ov;
    ef  = ~nv & ov;
    drive(s, nv);
    for (int i = 1; i <= lat; i++) exp_q.push_back((i < lat) ? ov : nv);
    for (int i = 1; i <= lat; i++) begin
      tick();
      check({tag, "_sync"},   o_sync,   exp_q.pop_front());
      check({tag, "_rise"},   o_rise,   (i == lat) ? er : 2'b00);
      check({tag, "_fall"},   o_fall,   (i == lat) ? ef : 2'b00);
      check({tag, "_glitch"}, o_glitch, 2'b00);
    end
    tick();
    check({tag, "_hold_sync"}, o_sync, nv);
    check({tag, "_hold_rise"}, o_rise, 2'b00);
    check({tag, "_hold_fall"}, o_fall, 2'b00);
  endtask

  initial begin
    // Test 1: reset with inputs low, then release.
    sel = 0;
    reset = 1'b1;
    a3 = 2'b00;
    a2 = 2'b00;
    repeat (2) begin
      tick();
      check("t1_rst_sync", o_sync, 2'b11);
      check("t1_rst_rise", o_rise, 2'b00);
      check("t1_rst_fall", o_fall, 2'b00);
      check("t1_rst_glitch", o_glitch, 2'b00);
    end
    reset = 1'b0;
    #1;
    check("t1_rel_sync", o_sync, 2'b11);
    check("t1_rel_fall", o_fall, 2'b00);
    for (int i = 1; i <= L3; i++) begin
      tick();
      check("t1_sync", o_sync, (i < L3) ? 2'b11 : 2'b00);
      check("t1_fall", o_fall, (i == L3) ? 2'b11 : 2'b00);
      check("t1_rise", o_rise, 2'b00);
      check("t1_glitch", o_glitch, 2'b00);
    end
    tick();
    check("t1_after_fall", o_fall, 2'b00);

    // Tests 2/3: single-channel falls with the other channel idle high.
    settle(0, 2'b11);
    transition("t2", 0, 2'b10);
    settle(0, 2'b11);
    transition("t3", 0, 2'b01);

    // Test 4: three-sample low excursion on channel 0.
    settle(0, 2'b11);
    a3 = 2'b10;
    for (int i = 1; i <= 9; i++) begin
      tick();
`ifdef SYNC_GLITCH_FILTER_EN
      check("t4_sync", o_sync, 2'b11);
      check("t4_rise", o_rise, 2'b00);
      check("t4_fall", o_fall, 2'b00);
      check("t4_glitch", o_glitch, (i == 7) ? 2'b01 : 2'b00);
`else
      check("t4_sync", o_sync, (i >= 3 && i <= 5) ? 2'b10 : 2'b11);
      check("t4_rise", o_rise, (i == 6) ? 2'b01 : 2'b00);
      check("t4_fall", o_fall, (i == 3) ? 2'b01 : 2'b00);
      check("t4_glitch", o_glitch, 2'b00);
`endif
      if (i == 3) a3 = 2'b11;
    end

    // Test 5: reset lands while a fall on channel 0 is still in flight.
    settle(0, 2'b11);
    a3 = 2'b10;
    repeat (5) tick();
    reset = 1'b1;
    #1;
    check("t5_rsthi_rise", o_rise, 2'b00);
    check("t5_rsthi_fall", o_fall, 2'b00);
    check("t5_rsthi_glitch", o_glitch, 2'b00);
    tick();
    check("t5_rst_sync", o_sync, 2'b11);
    check("t5_rst_fall", o_fall, 2'b00);
    a3 = 2'b11;
    reset = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      check("t5_sync", o_sync, 2'b11);
      check("t5_rise", o_rise, 2'b00);
      check("t5_fall", o_fall, 2'b00);
      check("t5_glitch", o_glitch, 2'b00);
    end

    // Test 6: opposite edges on both channels of the STAGES=2 instance.
    settle(1, 2'b10);
    transition("t6", 1, 2'b01);
    transition("t6b", 1, 2'b10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rx_sync_filter.md
Name: rx_sync_filter

Overview:
Multi-channel, parametrised input synchronizer for the UART Rx path and other asynchronous inputs such as handshakes and strap pins. Each channel passes its asynchronous input through a configurable-depth flop chain and can optionally apply a glitch filter. The block also produces registered-domain rise and fall pulses, so downstream logic (the Rx start-bit detector) does not need its own edge logic. It sits between the pad and the Rx FSM, one instance per async input group.

Parameters:
WIDTH, 1, number of independent channels.
STAGES, 3, synchronizer flops per channel; legal range 2..8. Any other value is an elaboration error.
RESET_VAL, {WIDTH{1'b1}}, WIDTH-bit value loaded into every stage and into sync_out on reset. UART idle is high.
FILTER_LEN, 4, consecutive differing samples required to accept a new level; legal 1..255. Used only with the filter macro.

Ports:
clk  input  1  system clock
reset  input  1  reset
async_in  input  WIDTH  asynchronous inputs, one bit per channel
sync_out  output  WIDTH  synchronized (and optionally filtered) level
rise_pulse  output  WIDTH  one-cycle pulse per channel on sync_out 0->1
fall_pulse  output  WIDTH  one-cycle pulse per channel on sync_out 1->0
glitch_det  output  WIDTH  one-cycle pulse when a rejected glitch ends; constant 0 without the filter

Behaviour:
- Interface (already decided): reset reset, synchronous, active-high; clock clk.
- Channels are fully independent. There is no cross-channel logic and no shared counters.
- Sync chain: stage[0] <= async_in[i]; stage[k] <= stage[k-1]. s_last = stage[STAGES-1].
- Reset, synchronous and active-high:
  - all stages, sync_out, the prev register and filter counters load RESET_VAL or 0 as appropriate;
  - rise_pulse, fall_pulse and glitch_det read 0 while reset is high;
  - rise_pulse, fall_pulse and glitch_det read 0 in the first cycle after reset;
  - reset mid-operation discards any in-flight transition.
- Power-up initial values equal the reset values, so simulation without reset is defined.
- Edge outputs:
  - prev <= sync_out every cycle;
  - rise_pulse = sync_out & ~prev; fall_pulse = ~sync_out & prev;
  - both are derived only from flops, so they are glitch-free;
  - each pulse is high exactly in the first cycle sync_out shows the new level;
  - rise_pulse and fall_pulse are never high together on one channel.
- Without filter: sync_out = s_last. An input change held before clock edge E appears on sync_out after edge E+STAGES-1, i.e. a latency of STAGES edges.
- Filter widths: counter width is clog2(FILTER_LEN+1). Counters saturate at no value above FILTER_LEN-1.
- Boundary: an input pulse shorter than one clock period may be lost. This is acceptable and is not asserted on.

Optional Feature:
Macro SYNC_GLITCH_FILTER_EN.
- Defined: each channel has a counter cnt, reset to 0, and sync_out becomes a separate flop. Each cycle:
  - if s_last == sync_out: cnt <= 0. If cnt was nonzero, glitch_det pulses for one cycle.
  - else if cnt == FILTER_LEN-1: sync_out <= s_last and cnt <= 0. This is an accepted change; no glitch_det.
  - else: cnt <= cnt+1.
- Resulting latency is STAGES+FILTER_LEN edges for a clean transition.
- Any excursion of FILTER_LEN-1 or fewer samples is suppressed: sync_out and the edge pulses are unaffected.
- FILTER_LEN=1 gives no suppression and adds one cycle of latency.
- Undefined: there are no counters, glitch_det is tied to 0, and the behaviour is exactly the non-filter path above.

Test Plan:
1. WIDTH=2, STAGES=3, async_in=2'b00. Hold reset 2 cycles, release -> sync_out=2'b11 during and after reset; no rise/fall/glitch pulse in the release cycle or the next 2 cycles. sync_out falls to 2'b00 on the 3rd edge after release, with fall_pulse=2'b11 for exactly 1 cycle.
2. No filter, STAGES=3, idle high. Drop async_in[0] to 0 and hold -> sync_out[0]=0 exactly 3 edges later; fall_pulse[0] high 1 cycle; rise_pulse=0; channel 1 unchanged.
3. Filter on, STAGES=3, FILTER_LEN=4. Drop async_in[1] to 0 and hold -> sync_out[1]=0 exactly 7 edges later; single fall_pulse[1]; glitch_det=0.
4. Filter on, FILTER_LEN=4. Pull async_in[0] low for 3 cycles then high -> sync_out[0] stays 1; no fall or rise pulse; glitch_det[0] pulses once, 3+3+1 edges after the glitch start.
5. Filter on. Assert reset when cnt[0]=2 during a low transition -> next cycle sync_out=RESET_VAL and cnt=0; no pulses. After release with async_in high, sync_out stays 1 with no edge.
6. WIDTH=2, no filter, STAGES=2. Drive ch0 0->1 and ch1 1->0 in the same cycle -> after 2 edges, rise_pulse=2'b01 and fall_pulse=2'b10 in the same single cycle.
